// File: rtl/flash_refill_ctrl_pkg.sv
// Shared constants, FSM state encoding and small helpers for the flash
// refill engine.
//   ADDR_WIDTH/DATA_WIDTH : word address and data widths
//   SUB_NUM/SUB_DEPTH     : number of sub-SRAMs and words per sub-SRAM
//   SUB_AW/IDX_W          : log2 of SUB_DEPTH and SUB_NUM
package flash_refill_ctrl_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SUB_NUM    = 4;
    localparam int SUB_DEPTH  = 16;
    localparam int SUB_AW     = 4;
    localparam int IDX_W      = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Align a word address down to the start of a sub-SRAM sized block.
    function automatic logic [ADDR_WIDTH-1:0] align_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & ~ADDR_WIDTH'(SUB_DEPTH - 1);
    endfunction

    // One-hot SRAM select; bit 0 is the main SRAM, so sub i maps to bit i+1.
    function automatic logic [SUB_NUM:0] sub_sel(input logic [IDX_W-1:0] idx);
        return {{SUB_NUM{1'b0}}, 1'b1} << (int'(idx) + 1);
    endfunction

endpackage

// File: rtl/flash_refill_ctrl_lru.sv
// Recency tracker for the sub-SRAMs.
//   clk, rst_n     : clock, async active-low reset (ages reset to age[i] = i)
//   touch_vld_i    : mark touch_idx_i as most recently used this cycle
//   touch_idx_i    : sub index to touch
//   valid_i        : per-sub valid bits, used to prefer empty slots
//   victim_o       : lowest-index invalid sub, else the sub with the oldest age
module flash_refill_ctrl_lru
    import flash_refill_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               touch_vld_i,
    input  logic [IDX_W-1:0]   touch_idx_i,
    input  logic [SUB_NUM-1:0] valid_i,
    output logic [IDX_W-1:0]   victim_o
);

    logic [IDX_W-1:0] age_q [SUB_NUM];
    logic [IDX_W-1:0] age_d [SUB_NUM];
    logic [IDX_W-1:0] inv_idx;
    logic [IDX_W-1:0] lru_idx;
    logic             any_inv;

    // Touch: everything younger than the touched entry ages by one, the
    // touched entry becomes 0. This keeps the ages a permutation.
    for (genvar gi = 0; gi < SUB_NUM; gi++) begin : g_age
        assign age_d[gi] = !touch_vld_i                         ? age_q[gi] :
                           (IDX_W'(gi) == touch_idx_i)          ? '0 :
                           (age_q[gi] < age_q[touch_idx_i])     ? age_q[gi] + 1'b1 :
                                                                  age_q[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SUB_NUM; i++) begin
                age_q[i] <= IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < SUB_NUM; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    always_comb begin
        inv_idx = '0;
        any_inv = 1'b0;
        lru_idx = '0;
        // Scan downwards so the lowest invalid index is the last one kept.
        for (int i = SUB_NUM - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                inv_idx = IDX_W'(i);
                any_inv = 1'b1;
            end
        end
        for (int i = 0; i < SUB_NUM; i++) begin
            if (age_q[i] == IDX_W'(SUB_NUM - 1)) begin
                lru_idx = IDX_W'(i);
            end
        end
        victim_o = any_inv ? inv_idx : lru_idx;
    end

endmodule

// File: rtl/flash_refill_ctrl.sv
// Miss-refill engine: on a miss, picks a victim sub-SRAM, streams one
// sub-SRAM worth of words from flash into it (one request outstanding,
// each returned beat followed by a write cycle), then publishes the new
// base address and valid bit.
//   clk, rst_n              : clock, async active-low reset (aborts a refill)
//   miss_req_i, miss_addr_i : miss pulse and missing word address
//   busy_o                  : refill in progress
//   refill_done_o           : 1-cycle pulse, sub written and tag valid
//   refill_idx_o            : victim index, stable from accept to done
//   hit_vld_i, hit_idx_i    : hit notification for recency tracking
//   flash_req_o/addr_o      : flash word request, held until rvalid
//   flash_rvalid_i/rdata_i  : flash data beat
//   ram_we_o/sel_o/waddr_o/wdata_o : SRAM write port (sel bit i+1 = sub i)
//   sub_base_o, sub_valid_o : per-sub base address and valid bit
module flash_refill_ctrl
    import flash_refill_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          miss_req_i,
    input  logic [ADDR_WIDTH-1:0]         miss_addr_i,
    output logic                          busy_o,
    output logic                          refill_done_o,
    output logic [IDX_W-1:0]              refill_idx_o,
    input  logic                          hit_vld_i,
    input  logic [IDX_W-1:0]              hit_idx_i,
    output logic                          flash_req_o,
    output logic [ADDR_WIDTH-1:0]         flash_addr_o,
    input  logic                          flash_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         flash_rdata_i,
    output logic                          ram_we_o,
    output logic [SUB_NUM:0]              ram_sel_o,
    output logic [SUB_AW-1:0]             ram_waddr_o,
    output logic [DATA_WIDTH-1:0]         ram_wdata_o,
    output logic [SUB_NUM*ADDR_WIDTH-1:0] sub_base_o,
    output logic [SUB_NUM-1:0]            sub_valid_o
);

    state_e                        state_q;
    logic [ADDR_WIDTH-1:0]         base_q;
    logic [SUB_AW-1:0]             cnt_q;
    logic                          busy_q;
    logic                          refill_done_q;
    logic [IDX_W-1:0]              refill_idx_q;
    logic                          flash_req_q;
    logic [ADDR_WIDTH-1:0]         flash_addr_q;
    logic                          ram_we_q;
    logic [SUB_NUM:0]              ram_sel_q;
    logic [SUB_AW-1:0]             ram_waddr_q;
    logic [DATA_WIDTH-1:0]         ram_wdata_q;
    logic [SUB_NUM*ADDR_WIDTH-1:0] sub_base_q;
    logic [SUB_NUM-1:0]            sub_valid_q;

    logic                          in_refill;
    logic                          touch_vld_d;
    logic [IDX_W-1:0]              touch_idx_d;
    logic [IDX_W-1:0]              victim;

    assign in_refill = (state_q == ST_FETCH) || (state_q == ST_WRITE);

    // The DONE touch wins over a same-cycle hit; hits on the sub being
    // refilled are stale and dropped.
    always_comb begin
        touch_vld_d = 1'b0;
        touch_idx_d = hit_idx_i;
        if (state_q == ST_DONE) begin
            touch_vld_d = 1'b1;
            touch_idx_d = refill_idx_q;
        end else if (hit_vld_i && !(in_refill && (hit_idx_i == refill_idx_q))) begin
            touch_vld_d = 1'b1;
        end
    end

    flash_refill_ctrl_lru u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .touch_vld_i (touch_vld_d),
        .touch_idx_i (touch_idx_d),
        .valid_i     (sub_valid_q),
        .victim_o    (victim)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            refill_done_q <= 1'b0;
            refill_idx_q  <= '0;
            flash_req_q   <= 1'b0;
            flash_addr_q  <= '0;
            ram_we_q      <= 1'b0;
            ram_sel_q     <= '0;
            ram_waddr_q   <= '0;
            ram_wdata_q   <= '0;
            sub_base_q    <= '0;
            sub_valid_q   <= '0;
        end else begin
            refill_done_q <= 1'b0;
            ram_we_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (miss_req_i) begin
                        base_q              <= align_base(miss_addr_i);
                        flash_addr_q        <= align_base(miss_addr_i);
                        cnt_q               <= '0;
                        refill_idx_q        <= victim;
                        // Invalidate now so sram_ctrl never hits on a half-written sub.
                        sub_valid_q[victim] <= 1'b0;
                        flash_req_q         <= 1'b1;
                        busy_q              <= 1'b1;
                        state_q             <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (flash_rvalid_i) begin
                        flash_req_q <= 1'b0;
                        ram_we_q    <= 1'b1;
                        ram_sel_q   <= sub_sel(refill_idx_q);
                        ram_waddr_q <= cnt_q;
                        ram_wdata_q <= flash_rdata_i;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (cnt_q == SUB_AW'(SUB_DEPTH - 1)) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        // Wraps modulo 2^ADDR_WIDTH by construction.
                        flash_addr_q <= base_q + ADDR_WIDTH'(cnt_q + 1'b1);
                        flash_req_q  <= 1'b1;
                        state_q      <= ST_FETCH;
                    end
                end
                ST_DONE: begin
                    sub_base_q[refill_idx_q*ADDR_WIDTH +: ADDR_WIDTH] <= base_q;
                    sub_valid_q[refill_idx_q] <= 1'b1;
                    refill_done_q             <= 1'b1;
                    busy_q                    <= 1'b0;
                    state_q                   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign refill_done_o = refill_done_q;
    assign refill_idx_o  = refill_idx_q;
    assign flash_req_o   = flash_req_q;
    assign flash_addr_o  = flash_addr_q;
    assign ram_we_o      = ram_we_q;
    assign ram_sel_o     = ram_sel_q;
    assign ram_waddr_o   = ram_waddr_q;
    assign ram_wdata_o   = ram_wdata_q;
    assign sub_base_o    = sub_base_q;
    assign sub_valid_o   = sub_valid_q;

endmodule

// File: tb/tb_flash_refill_ctrl.sv
// Directed bench for flash_refill_ctrl: drives misses, hits and a flash
// responder with configurable wait states, and checks the write stream,
// flash addresses, latency, tags and recency ages against hand-derived values.
module tb_flash_refill_ctrl;

    logic         clk;
    logic         rst_n;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         busy;
    logic         refill_done;
    logic [1:0]   refill_idx;
    logic         hit_vld;
    logic [1:0]   hit_idx;
    logic         flash_req;
    logic [31:0]  flash_addr;
    logic         flash_rvalid;
    logic [31:0]  flash_rdata;
    logic         ram_we;
    logic [4:0]   ram_sel;
    logic [3:0]   ram_waddr;
    logic [31:0]  ram_wdata;
    logic [127:0] sub_base;
    logic [3:0]   sub_valid;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    flash_refill_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_req_i     (miss_req),
        .miss_addr_i    (miss_addr),
        .busy_o         (busy),
        .refill_done_o  (refill_done),
        .refill_idx_o   (refill_idx),
        .hit_vld_i      (hit_vld),
        .hit_idx_i      (hit_idx),
        .flash_req_o    (flash_req),
        .flash_addr_o   (flash_addr),
        .flash_rvalid_i (flash_rvalid),
        .flash_rdata_i  (flash_rdata),
        .ram_we_o       (ram_we),
        .ram_sel_o      (ram_sel),
        .ram_waddr_o    (ram_waddr),
        .ram_wdata_o    (ram_wdata),
        .sub_base_o     (sub_base),
        .sub_valid_o    (sub_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ages packed as {age3, age2, age1, age0}.
    task automatic chk_ages(input string tag, input logic [7:0] exp);
        chk(tag, {u_dut.u_lru.age_q[3], u_dut.u_lru.age_q[2],
                  u_dut.u_lru.age_q[1], u_dut.u_lru.age_q[0]}, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"}, {busy, refill_done, refill_idx, flash_req, flash_addr, ram_we,
                                ram_sel, ram_waddr, ram_wdata, sub_valid}, '0);
        chk({tag, " sub_base"}, sub_base, '0);
        chk_ages({tag, " ages"}, 8'b11_10_01_00);
    endtask

    // One complete miss/refill transaction. Optional extras: a second miss
    // pulse at miss_cyc, a hit at hit_cyc, spurious rvalid outside FETCH,
    // and an async reset when word abort_word is being fetched.
    task automatic refill(input string tag, input logic [31:0] addr, input logic [1:0] exp_idx,
                          input int wait_n, input int exp_cyc, input int miss_cyc,
                          input int hit_cyc, input logic [1:0] hit_i, input bit spurious,
                          input int abort_word);
        logic [31:0] base;
        int k = 0, cyc = 0, wcnt = 0, bad_addr = 0, bad_wr = 0, bad_idx = 0;
        bit done = 0, aborted = 0;
        base = addr & ~32'hF;
        @(negedge clk);
        miss_req  = 1'b1;
        miss_addr = addr;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            miss_req = 1'b0;
            hit_vld  = 1'b0;
            if (cyc == miss_cyc) begin
                miss_req  = 1'b1;
                miss_addr = 32'h0000_0900;
            end
            if (cyc == hit_cyc) begin
                hit_vld = 1'b1;
                hit_idx = hit_i;
            end
            if (cyc == 1) chk({tag, " busy"}, busy, 1'b1);
            if (refill_idx !== exp_idx) bad_idx++;
            if (ram_we) begin
                if (ram_sel !== 5'(1 << (int'(exp_idx) + 1)) || ram_waddr !== k[3:0] ||
                    ram_wdata !== fdata(base + k)) bad_wr++;
                k++;
            end
            if (flash_req) begin
                if (flash_addr !== base + k) bad_addr++;
                if (wcnt >= wait_n) begin
                    flash_rvalid = 1'b1;
                    flash_rdata  = fdata(base + k);
                    wcnt = 0;
                end else begin
                    flash_rvalid = 1'b0;
                    wcnt++;
                end
            end else begin
                flash_rvalid = spurious && busy;
                flash_rdata  = 32'hDEAD_BEEF;
                wcnt = 0;
            end
            if (abort_word >= 0 && k == abort_word && flash_req) begin
                rst_n        = 1'b0;
                flash_rvalid = 1'b0;
                aborted      = 1'b1;
                break;
            end
            if (refill_done) done = 1'b1;
        end
        miss_req     = 1'b0;
        hit_vld      = 1'b0;
        flash_rvalid = 1'b0;
        if (aborted) begin
            #1;
            chk_all_zero({tag, " abort"});
            @(negedge clk);
            rst_n = 1'b1;
            $display("refill %s aborted at word %0d cycle %0d", tag, k, cyc);
        end else begin
            chk({tag, " done"}, done, 1'b1);
            chk({tag, " latency"}, cyc, exp_cyc);
            chk({tag, " words"}, k, 16);
            chk({tag, " bad writes"}, bad_wr, 0);
            chk({tag, " bad flash addr"}, bad_addr, 0);
            chk({tag, " idx unstable"}, bad_idx, 0);
            chk({tag, " busy at done"}, busy, 1'b0);
            $display("refill %s base=%h idx=%0d cycles=%0d words=%0d", tag, base, refill_idx, cyc, k);
        end
    endtask

    task automatic chk_base(input string tag, input int idx, input logic [31:0] exp);
        chk(tag, sub_base[idx*32 +: 32], exp);
    endtask

    initial begin
        clk = 0; rst_n = 0; miss_req = 0; miss_addr = 0; hit_vld = 0; hit_idx = 0;
        flash_rvalid = 0; flash_rdata = 0;
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 1: first refill into empty sub 0, zero-wait flash.
        refill("t1", 32'h123, 2'd0, 0, 34, -1, -1, 2'd0, 0, -1);
        chk_base("t1 base0", 0, 32'h120);
        chk("t1 valid", sub_valid, 4'b0001);
        chk_ages("t1 ages", 8'b11_10_01_00);

        @(negedge clk); rst_n = 1'b0;
        #1 chk_all_zero("reset2");
        @(negedge clk); rst_n = 1'b1;

        // 2: fill all four, then hit 0 makes 1 the LRU victim.
        refill("t2a", 32'h000, 2'd0, 0, 34, -1, -1, 2'd0, 0, -1);
        refill("t2b", 32'h100, 2'd1, 0, 34, -1, -1, 2'd0, 0, -1);
        refill("t2c", 32'h200, 2'd2, 0, 34, -1, -1, 2'd0, 0, -1);
        refill("t2d", 32'h300, 2'd3, 0, 34, -1, -1, 2'd0, 0, -1);
        chk("t2 valid", sub_valid, 4'b1111);
        chk_ages("t2 ages", 8'b00_01_10_11);
        @(negedge clk); hit_vld = 1'b1; hit_idx = 2'd0;
        @(negedge clk); hit_vld = 1'b0;
        chk_ages("t2 hit ages", 8'b01_10_11_00);
        refill("t2e", 32'h400, 2'd1, 0, 34, -1, -1, 2'd0, 0, -1);
        chk_base("t2 base1", 1, 32'h400);
        chk_base("t2 base0", 0, 32'h000);
        chk_ages("t2e ages", 8'b10_11_00_01);

        // 3: three wait cycles per beat -> 5 cycles per word.
        refill("t3", 32'h50A, 2'd2, 3, 82, -1, -1, 2'd0, 0, -1);
        chk_base("t3 base2", 2, 32'h500);
        chk_ages("t3 ages", 8'b11_00_01_10);

        // 6: hit on sub 1 in the DONE cycle (cycle 33) of the refill of sub 3;
        // sub 1 is not MRU, so a wrongly applied touch would show in the ages.
        refill("t6", 32'h600, 2'd3, 0, 34, -1, 33, 2'd1, 0, -1);
        chk_base("t6 base3", 3, 32'h600);
        chk_ages("t6 ages", 8'b00_01_10_11);

        // 4: miss pulse during FETCH, hit on the victim, spurious rvalid.
        refill("t4", 32'h7FF, 2'd0, 0, 34, 5, 7, 2'd0, 1, -1);
        chk_base("t4 base0", 0, 32'h7F0);
        chk("t4 valid", sub_valid, 4'b1111);
        chk_ages("t4 ages", 8'b01_10_11_00);

        // 5: async reset while fetching word 7, then a clean refill.
        refill("t5", 32'hA00, 2'd1, 0, 34, -1, -1, 2'd0, 0, 7);
        refill("t5b", 32'hB05, 2'd0, 0, 34, -1, -1, 2'd0, 0, -1);
        chk_base("t5b base0", 0, 32'hB00);
        chk("t5b valid", sub_valid, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
